// File: rtl/rk_ctrl_multi.sv
// rk_ctrl_multi: RK8-E style disk controller front-end; IOT decode, status, backend req/ack/done FSM.
// Optional feature macro RK_MAINT_EN: x7 (DMAN) diagnostic readback and forced backend error.
module rk_ctrl_multi #(
  parameter logic [5:0] DEV_CODE   = 6'o74,
  parameter int         NUM_DRIVES = 4,
  parameter int         MAX_CYL    = 203,
  parameter int         WORDS_FULL = 256,
  parameter int         WORDS_HALF = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [0:11] instruction,
  input  logic [4:0]  state,
  input  logic [0:11] ac,
  input  logic        UF,
  output logic [0:11] disk_bus,
  output logic        skip,
  output logic        interrupt,
  output logic        be_req,
  output logic [1:0]  be_op,
  output logic [2:0]  be_drive,
  output logic [12:0] be_daddr,
  output logic [14:0] be_maddr,
  output logic [8:0]  be_len,
  input  logic        be_ack,
  input  logic        be_done,
  input  logic        be_err,
  output logic        be_abort
);

  localparam logic [4:0] F1 = 5'b00001;
  localparam logic [4:0] F2 = 5'b00010;

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, ISSUE = 2'd2, BUSY = 2'd3} fsm_t;
  fsm_t fsm_reg, fsm_next;

  logic [0:11] cmd_reg, dar_reg, car_reg, bus_reg;
  logic        done_reg, busy_reg, wl_err_reg, drv_err_reg, cyl_err_reg;
  logic        done_next, busy_next, wl_err_next, drv_err_next, cyl_err_next;
  logic [7:0]  write_lock_reg;
  logic        lock_pend_reg, skip_reg, irq_reg, abort_reg, abort_next;
  logic [0:11] status;
  logic        disk_flag, iot_cycle, caf, init, op_valid, is_write, is_seek, force_err;
  logic [2:0]  iot_op, drive;
  logic [7:0]  cyl;

  assign iot_cycle = (state == F1) && !UF && (instruction[0:2] == 3'b110) &&
                     (instruction[3:8] == DEV_CODE);
  assign caf       = (state == F1) && !UF && (instruction == 12'o6007);
  assign init      = reset | clear | caf;
  assign iot_op    = instruction[9:11];

  // The command word only has room for a 2-bit unit field; the top drive bit is always 0.
  assign drive     = {1'b0, cmd_reg[9:10]};
  assign cyl       = {cmd_reg[11], dar_reg[0:6]};
  assign is_write  = cmd_reg[0] && !cmd_reg[1];
  assign is_seek   = (cmd_reg[0:2] == 3'b011);
  assign op_valid  = (cmd_reg[0:2] != 3'b010) && (cmd_reg[0:2] != 3'b110) &&
                     (cmd_reg[0:2] != 3'b111);

  assign status    = {done_reg, 4'b0000, busy_reg, 1'b0, wl_err_reg, 2'b00, drv_err_reg, cyl_err_reg};
  assign disk_flag = done_reg | wl_err_reg | drv_err_reg | cyl_err_reg;

  // Backend fields are only presented while a request is outstanding.
  assign be_req    = (fsm_reg == ISSUE);
  assign be_op     = !be_req ? 2'b00 : is_write ? 2'b01 : is_seek ? 2'b10 : 2'b00;
  assign be_drive  = be_req ? drive : 3'd0;
  assign be_daddr  = be_req ? {cmd_reg[11], dar_reg} : 13'd0;
  assign be_maddr  = be_req ? {cmd_reg[6:8], car_reg} : 15'd0;
  assign be_len    = !be_req ? 9'd0 : cmd_reg[5] ? 9'(WORDS_HALF) : 9'(WORDS_FULL);

  assign disk_bus  = bus_reg;
  assign skip      = skip_reg;
  assign interrupt = irq_reg;
  assign be_abort  = abort_reg;

`ifdef RK_MAINT_EN
  logic force_err_reg;
  assign force_err = force_err_reg;

  always_ff @(posedge clk) begin
    if (init)
      force_err_reg <= 1'b0;
    else if (iot_cycle && iot_op == 3'd7 && ac[0])
      force_err_reg <= 1'b1;
    else if (fsm_reg == BUSY && be_done)
      force_err_reg <= 1'b0;
  end
`else
  assign force_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (init) fsm_reg <= IDLE;
    else      fsm_reg <= fsm_next;
  end

  // FSM events are applied first; IOT status clears come last so a DCLC abort beats be_done.
  always_comb begin
    fsm_next     = fsm_reg;
    done_next    = done_reg;
    busy_next    = busy_reg;
    wl_err_next  = wl_err_reg;
    drv_err_next = drv_err_reg;
    cyl_err_next = cyl_err_reg;
    abort_next   = 1'b0;
    case (fsm_reg)
      CHECK: begin
        fsm_next  = IDLE;
        busy_next = 1'b0;
        done_next = 1'b1;
        if (int'(drive) >= NUM_DRIVES)               drv_err_next = 1'b1;
        else if (int'(cyl) > MAX_CYL)                cyl_err_next = 1'b1;
        else if (is_write && write_lock_reg[drive])  wl_err_next  = 1'b1;
        else begin
          fsm_next  = ISSUE;
          busy_next = busy_reg;
          done_next = done_reg;
        end
      end
      ISSUE: if (be_ack) begin
        fsm_next = BUSY;
        if (is_seek && !cmd_reg[4]) done_next = 1'b1;
      end
      BUSY: if (be_done) begin
        fsm_next     = IDLE;
        busy_next    = 1'b0;
        done_next    = 1'b1;
        drv_err_next = drv_err_reg | be_err | force_err;
      end
      default: ;
    endcase
    if (lock_pend_reg && state == F2) done_next = 1'b1;
    if (iot_cycle) begin
      case (iot_op)
        3'd2: begin
          {done_next, busy_next, wl_err_next, drv_err_next, cyl_err_next} = '0;
          if (ac[11]) begin
            abort_next = 1'b1;
            fsm_next   = IDLE;
          end
        end
        3'd3: begin
          if (fsm_reg != IDLE) drv_err_next = 1'b1;
          else if (op_valid) begin
            {done_next, busy_next, wl_err_next, drv_err_next, cyl_err_next} = '0;
            busy_next = 1'b1;
            fsm_next  = CHECK;
          end else done_next = 1'b1;
        end
        3'd6: {done_next, busy_next, wl_err_next, drv_err_next, cyl_err_next} = '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      cmd_reg <= '0; dar_reg <= '0; car_reg <= '0; bus_reg <= '0;
      {done_reg, busy_reg, wl_err_reg, drv_err_reg, cyl_err_reg} <= '0;
      write_lock_reg <= '0;
      lock_pend_reg  <= 1'b0;
      skip_reg       <= 1'b0;
      irq_reg        <= 1'b0;
      abort_reg      <= 1'b0;
    end else begin
      done_reg    <= done_next;
      busy_reg    <= busy_next;
      wl_err_reg  <= wl_err_next;
      drv_err_reg <= drv_err_next;
      cyl_err_reg <= cyl_err_next;
      abort_reg   <= abort_next;
      irq_reg     <= disk_flag & cmd_reg[3];
      lock_pend_reg <= iot_cycle && (iot_op == 3'd6) && (ac[0:2] == 3'b010);
      if (lock_pend_reg && state == F2) write_lock_reg[drive] <= 1'b1;
      if (iot_cycle) begin
        skip_reg <= (iot_op == 3'd1) && disk_flag;
        case (iot_op)
          3'd3: if (fsm_reg == IDLE) dar_reg <= ac;
          3'd4: car_reg <= ac;
          3'd5: bus_reg <= status;
          3'd6: cmd_reg <= ac;
`ifdef RK_MAINT_EN
          3'd7: bus_reg <= {2'(fsm_reg), 7'd0, drive};
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rk_ctrl_multi.sv
// Bench for rk_ctrl_multi: directed and randomized IOT sequences against an operation-level model.
module tb_rk_ctrl_multi;

  localparam int         ND   = 3;
  localparam int         MAXC = 203;
  localparam logic [5:0] DEV  = 6'o74;
  localparam logic [4:0] F1   = 5'b00001;
  localparam logic [4:0] F2   = 5'b00010;
  localparam int DONE = 'o4000, BUSY = 'o0100, WL = 'o0020, DRV = 'o0002, CYL = 'o0001;

  logic        clk = 1'b0;
  logic        reset, clear, UF;
  logic [0:11] instruction, ac, disk_bus;
  logic [4:0]  state;
  logic        skip, interrupt, be_req, be_ack, be_done, be_err, be_abort;
  logic [1:0]  be_op;
  logic [2:0]  be_drive;
  logic [12:0] be_daddr;
  logic [14:0] be_maddr;
  logic [8:0]  be_len;

  int total = 0;
  int bad   = 0;
  bit abort_f2;
  int m_cmd, m_status;
  bit m_lock [8];

  rk_ctrl_multi #(.NUM_DRIVES(ND)) dut (
    .clk(clk), .reset(reset), .clear(clear), .instruction(instruction), .state(state),
    .ac(ac), .UF(UF), .disk_bus(disk_bus), .skip(skip), .interrupt(interrupt),
    .be_req(be_req), .be_op(be_op), .be_drive(be_drive), .be_daddr(be_daddr),
    .be_maddr(be_maddr), .be_len(be_len), .be_ack(be_ack), .be_done(be_done),
    .be_err(be_err), .be_abort(be_abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0o expected %0o", tag, obs, exp);
    end
  endtask

  task automatic iot(input logic [2:0] op, input int acv, input bit with_done);
    @(negedge clk);
    instruction = {3'b110, DEV, op}; state = F1; ac = 12'(acv); be_done = with_done;
    @(negedge clk);
    abort_f2 = be_abort;
    instruction = '0; state = F2; be_done = 1'b0;
    @(negedge clk);
    state = 5'd0;
  endtask

  task automatic pulse_ack();
    @(negedge clk); be_ack = 1'b1;
    @(negedge clk); be_ack = 1'b0;
  endtask

  task automatic pulse_done(input bit err);
    @(negedge clk); be_done = 1'b1; be_err = err;
    @(negedge clk); be_done = 1'b0; be_err = 1'b0;
  endtask

  task automatic check_status(input string tag);
    bit flag;
    flag = (m_status & (DONE | WL | DRV | CYL)) != 0;
    iot(3'd5, 0, 0);
    $display("txn %s: status=%04o model=%04o", tag, disk_bus, m_status);
    check({tag, " status"}, disk_bus, m_status);
    check({tag, " interrupt"}, interrupt, flag && ((m_cmd & 'o400) != 0));
    iot(3'd1, 0, 0);
    check({tag, " skip"}, skip, flag);
  endtask

  // One full command: DLDC, DLCA, DLAG, then backend handshake if a request is expected.
  task automatic run_op(input int cmdv, input int carv, input int darv, input bit err, input bit poke);
    int op, drv, cyl;
    bit req;
    op  = (cmdv >> 9) & 7;
    drv = (cmdv >> 1) & 3;
    iot(3'd6, cmdv, 0);
    m_cmd = cmdv; m_status = 0;
    if (op == 2) begin m_lock[drv] = 1'b1; m_status = DONE; end
    iot(3'd4, carv, 0);
    iot(3'd3, darv, 0);
    cyl = ((cmdv & 1) << 7) | (darv >> 5);
    req = 1'b0;
    if (!(op inside {0, 1, 3, 4, 5}))    m_status |= DONE;
    else if (drv >= ND)                  m_status = DONE | DRV;
    else if (cyl > MAXC)                 m_status = DONE | CYL;
    else if (op >= 4 && m_lock[drv])    m_status = DONE | WL;
    else begin m_status = BUSY; req = 1'b1; end
    $display("txn op cmd=%04o car=%04o dar=%04o req=%0d", cmdv, carv, darv, be_req);
    check("be_req", be_req, req);
    if (req) begin
      check("be_op", be_op, op >= 4 ? 1 : (op == 3 ? 2 : 0));
      check("be_drive", be_drive, drv);
      check("be_daddr", be_daddr, ((cmdv & 1) << 12) | darv);
      check("be_maddr", be_maddr, (((cmdv >> 3) & 7) << 12) | carv);
      check("be_len", be_len, (cmdv & 'o100) != 0 ? 128 : 256);
      pulse_ack();
      if (op == 3 && (cmdv & 'o200) == 0) m_status |= DONE;
      check_status("ack");
      if (poke) begin
        iot(3'd3, 'o1234, 0);
        m_status |= DRV;
      end
      pulse_done(err);
      m_status = (m_status & ~BUSY) | DONE | (err ? DRV : 0);
    end
    check_status("end");
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; UF = 1'b0; instruction = '0; ac = '0; state = 5'd0;
    be_ack = 1'b0; be_done = 1'b0; be_err = 1'b0;
    m_cmd = 0; m_status = 0;
    foreach (m_lock[i]) m_lock[i] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst disk_bus", disk_bus, 0);
    check("rst skip", skip, 0);
    check("rst interrupt", interrupt, 0);
    check("rst be_req", be_req, 0);
    check("rst be_len", be_len, 0);
    check("rst be_abort", be_abort, 0);
    check_status("reset");

    run_op('o0400, 'o0200, 0, 0, 0);        // read, IE, drive 0
    run_op('o2000, 0, 0, 0, 0);             // write-lock drive 0
    run_op('o5000, 'o1000, 'o0100, 0, 0);   // write to locked drive
    run_op('o0001, 0, 'o4540, 0, 0);        // cylinder 203: legal
    run_op('o0001, 0, 'o4600, 0, 0);        // cylinder 204: error
    run_op('o0406, 0, 0, 0, 0);             // drive 3 with 3 drives
    run_op('o4104, 'o0777, 'o0010, 1, 0);   // write drive 2, half block, backend error
    run_op('o6400, 0, 0, 0, 0);             // unsupported op
    run_op('o3400, 0, 'o0100, 0, 1);        // seek, done at ack, DLAG while busy
    run_op('o3600, 0, 0, 0, 0);             // seek, done waits for be_done

    // Abort while the request is outstanding; a late be_done must be ignored.
    iot(3'd6, 'o0400, 0);
    iot(3'd3, 0, 0);
    check("abort pre be_req", be_req, 1);
    iot(3'd2, 1, 0);
    check("abort pulse", abort_f2, 1);
    check("abort one cycle", be_abort, 0);
    check("abort be_req", be_req, 0);
    pulse_done(1'b0);
    m_cmd = 'o0400; m_status = 0;
    check_status("abort");
    // Abort coinciding with be_done.
    iot(3'd3, 0, 0);
    pulse_ack();
    iot(3'd2, 1, 1);
    check_status("abort+done");

    // CAF clears registers and write locks.
    @(negedge clk); instruction = 12'o6007; state = F1;
    @(negedge clk); instruction = '0; state = F2;
    @(negedge clk); state = 5'd0;
    check("caf disk_bus", disk_bus, 0);
    m_cmd = 0; m_status = 0;
    foreach (m_lock[i]) m_lock[i] = 1'b0;
    check_status("caf");
    run_op('o5000, 0, 0, 0, 0);

    // User mode suppresses IOTs.
    UF = 1'b1;
    iot(3'd6, 'o0400, 0);
    UF = 1'b0;
    check_status("uf");

    for (int n = 0; n < 25; n++) begin
      int cmdv;
      cmdv = (int'($urandom_range(0, 7)) << 9) | int'($urandom_range(0, 511));
      run_op(cmdv, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
